alu_acc: RTL

Parametrised, registered successor to the 16-bit combinational ALU: a WIDTH-bit, eight-operation ALU with an internal accumulator, a valid/ready input handshake and a one-cycle registered result. Arithmetic faults drive a sticky ERROR state that blocks new work until it is explicitly cleared. The block sits between the operand/op-code source and the display/next-state logic, and replaces the separate ALU, accumulator and error-state modules.

---
 rtl/alu_acc.sv | 125 ++++++++++++
 1 files changed

// File: rtl/alu_acc.sv
// alu_acc: registered WIDTH-bit ALU with accumulator, handshake and sticky error.
// Optional feature macro: ALU_SAT_EN (saturate add/shl overflow instead of ERROR).
module alu_acc #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             use_acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_err,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             neg,
    output logic             sat,
    output logic             err,
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] op_cnt
);

    localparam logic [0:0] ST_RUN = 1'b0;
    localparam logic [0:0] ST_ERR = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};

    logic [0:0]       state;
    logic             accept;
    logic [WIDTH-1:0] opa;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res_c;
    logic             neg_c;
    logic             ovf;

    assign in_ready = (state == ST_RUN);
    assign err      = (state == ST_ERR);
    assign accept   = in_valid && in_ready;
    assign opa      = use_acc ? acc : a;
    assign sum      = {1'b0, opa} + {1'b0, b};

    // Next result, sign flag and overflow for the presented op.
    always_comb begin
        res_c = '0;
        neg_c = 1'b0;
        ovf   = 1'b0;
        unique case (op)
            3'b000: begin
                res_c = sum[WIDTH-1:0];
                ovf   = sum[WIDTH];
            end
            3'b001: begin
                if (b > opa) begin
                    res_c = b - opa;
                    neg_c = 1'b1;
                end else begin
                    res_c = opa - b;
                end
            end
            3'b010: begin
                res_c = {opa[WIDTH-2:0], 1'b0};
                ovf   = opa[WIDTH-1];
            end
            3'b011: res_c = {1'b0, opa[WIDTH-1:1]};
            3'b100: res_c = opa & b;
            3'b101: res_c = opa | b;
            3'b110: res_c = opa ^ b;
            3'b111: res_c = ~opa;
        endcase
    end

`ifdef ALU_SAT_EN
    logic sat_q;
    assign sat = sat_q;

    // Saturation flag is registered alongside the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (accept) begin
            sat_q <= ovf;
        end
    end
`else
    assign sat = 1'b0;
`endif

    // Result, accumulator, counter and RUN/ERROR state update on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            out_valid <= 1'b0;
            result    <= '0;
            neg       <= 1'b0;
            acc       <= '0;
            op_cnt    <= '0;
        end else begin
            out_valid <= accept;
            if (accept) begin
                op_cnt <= op_cnt + CNT_ONE;
                if (!ovf) begin
                    result <= res_c;
                    neg    <= neg_c;
                    acc    <= res_c;
                end else begin
`ifdef ALU_SAT_EN
                    result <= ONES;
                    neg    <= 1'b0;
                    acc    <= ONES;
`else
                    result <= '0;
                    neg    <= 1'b0;
                    state  <= ST_ERR;
`endif
                end
            end else if (state == ST_ERR && clr_err) begin
                state <= ST_RUN;
            end
        end
    end

endmodule
